// File: rtl/mbc7_tilt_conditioner.sv
// mbc7_tilt_conditioner: per-axis centre calibration, offset removal, deadzone,
// EMA low-pass and slew limiting of raw stick samples feeding the MBC7 tilt latch.
module mbc7_tilt_conditioner #(
    parameter int SAMPLE_DIV = 4096,
    parameter int SHIFT      = 3,
    parameter int DEADZONE   = 8,
    parameter int SLEW_MAX   = 16
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       ce,
    input  logic [7:0] joy_x_in,
    input  logic [7:0] joy_y_in,
    input  logic       cal_req,
    input  logic       freeze,
    output logic [7:0] joy_x_out,
    output logic [7:0] joy_y_out,
    output logic       sample_stb,
    output logic       cal_busy
);
    localparam int AW = 8 + SHIFT;
    localparam logic signed [7:0] DZ = 8'(DEADZONE);
    localparam logic signed [8:0] SL = 9'(SLEW_MAX);
    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

    typedef enum logic {RUN, CAL} state_t;

    state_t               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [3:0]           cal_cnt_q, cal_cnt_d;
    logic signed [11:0]   sum_q [2], sum_d [2];
    logic signed [7:0]    off_q [2], off_d [2];
    logic signed [7:0]    raw_q [2], raw_d [2];
    logic signed [7:0]    dz_q  [2], dz_d  [2];
    logic signed [AW-1:0] acc_q [2], acc_d [2];
    logic signed [7:0]    out_q [2], out_d [2];
    logic                 v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, stb_q, stb_d;
    logic                 tick;
    logic signed [7:0]    in_s [2];
    logic signed [11:0]   nsum [2];

    // Saturating offset removal followed by deadzone shrink toward zero.
    function automatic logic signed [7:0] condition(input logic signed [7:0] raw, input logic signed [7:0] off);
        logic signed [8:0] d;
        logic signed [7:0] s;
        d = {raw[7], raw} - {off[7], off};
        s = d > 9'sd127 ? 8'sd127 : d < -9'sd128 ? 8'h80 : d[7:0];
        return s > DZ ? s - DZ : s < -DZ ? s + DZ : 8'sd0;
    endfunction

    function automatic logic signed [7:0] slew(input logic signed [7:0] cur, input logic signed [7:0] tgt);
        logic signed [8:0] c, delta;
        c     = {cur[7], cur};
        delta = {tgt[7], tgt} - c;
        c     = delta > SL ? c + SL : delta < -SL ? c - SL : {tgt[7], tgt};
        return c[7:0];
    endfunction

    always_comb begin
        in_s[0]   = joy_x_in;
        in_s[1]   = joy_y_in;
        tick      = ce && cnt_q == DIV_LAST;
        cnt_d     = tick ? 16'd0 : cnt_q + 16'(ce);
        state_d   = state_q;
        cal_cnt_d = cal_cnt_q;
        v0_d      = tick;
        v1_d      = v0_q;
        v2_d      = v1_q;
        stb_d     = v2_q && !freeze;
        for (int i = 0; i < 2; i++) begin
            nsum[i]  = sum_q[i] + 12'(in_s[i]);
            sum_d[i] = sum_q[i];
            off_d[i] = off_q[i];
            raw_d[i] = tick ? in_s[i] : raw_q[i];
            dz_d[i]  = v0_q ? condition(raw_q[i], off_q[i]) : dz_q[i];
            acc_d[i] = v1_q ? acc_q[i] + AW'(dz_q[i]) - (acc_q[i] >>> SHIFT) : acc_q[i];
            out_d[i] = stb_d ? slew(out_q[i], 8'(acc_q[i] >>> SHIFT)) : out_q[i];
        end
        if (state_q == RUN && cal_req) begin
            state_d   = CAL;
            cal_cnt_d = 4'd0;
            for (int i = 0; i < 2; i++) sum_d[i] = '0;
        end else if (state_q == CAL && tick) begin
            cal_cnt_d = cal_cnt_q + 4'd1;
            for (int i = 0; i < 2; i++) sum_d[i] = nsum[i];
            // 16th sample: the new centre is the mean, and the filter restarts from it
            if (cal_cnt_q == 4'd15) begin
                state_d = RUN;
                for (int i = 0; i < 2; i++) begin
                    off_d[i] = nsum[i][11:4];
                    acc_d[i] = '0;
                end
            end
        end
        if (!enable) begin
            state_d   = RUN;
            cnt_d     = '0;
            cal_cnt_d = '0;
            v0_d      = 1'b0;
            v1_d      = 1'b0;
            v2_d      = 1'b0;
            stb_d     = 1'b0;
            for (int i = 0; i < 2; i++) begin
                sum_d[i] = '0;
                off_d[i] = '0;
                raw_d[i] = '0;
                dz_d[i]  = '0;
                acc_d[i] = '0;
                out_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            cal_cnt_q <= '0;
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            stb_q     <= 1'b0;
            sum_q     <= '{default: '0};
            off_q     <= '{default: '0};
            raw_q     <= '{default: '0};
            dz_q      <= '{default: '0};
            acc_q     <= '{default: '0};
            out_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cal_cnt_q <= cal_cnt_d;
            v0_q      <= v0_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            stb_q     <= stb_d;
            sum_q     <= sum_d;
            off_q     <= off_d;
            raw_q     <= raw_d;
            dz_q      <= dz_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
        end
    end

    assign joy_x_out  = out_q[0];
    assign joy_y_out  = out_q[1];
    assign sample_stb = stb_q;
    assign cal_busy   = state_q == CAL;
endmodule
